wb_ram_arbiter: RTL and testbench

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_ram_arb_pkg.sv | 17 +
 rtl/wb_ram_arb_wdog.sv | 28 ++
 rtl/wb_ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_arb_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
// Imported by the arbiter top and its watchdog.
package wb_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/wb_ram_arb_wdog.sv
// Ack watchdog: counts stalled strobe cycles and flags expiry at the limit.
// The count never passes the limit and restarts after expiry.
module wb_ram_arb_wdog
    import wb_ram_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr,
    input  logic              run,
    input  logic [WDOG_W-1:0] limit,
    output logic              expire
);

    logic [WDOG_W-1:0] cnt_q;

    assign expire = (cnt_q == limit);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr || expire) begin
            cnt_q <= '0;
        end else if (run && (cnt_q < limit)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave,
// with an ack watchdog that terminates stalled cycles with err.
module wb_ram_arbiter
    import wb_ram_arb_pkg::*;
#(
    parameter int AW  = 11,
    parameter int DW  = 32,
    parameter int TMO = 15
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_data_i,
    output logic [1:0]    gnt_o
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TMO);

    arb_state_t state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;

    logic          g_cyc, g_stb, g_we;
    logic [3:0]    g_sel;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    logic expire, wd_clr, wd_run;
    logic ack_hit, err_hit;

    // last_q high means master 1 was served last, so master 0 wins a tie
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    gnt_d   = GNT_M0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    gnt_d   = GNT_M1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_sel  = '0;
        g_addr = '0;
        g_data = '0;
        unique case (1'b1)
            gnt_q[0]: begin
                g_cyc  = m0_cyc_i;
                g_stb  = m0_stb_i;
                g_we   = m0_we_i;
                g_sel  = m0_sel_i;
                g_addr = m0_addr_i;
                g_data = m0_data_i;
            end
            gnt_q[1]: begin
                g_cyc  = m1_cyc_i;
                g_stb  = m1_stb_i;
                g_we   = m1_we_i;
                g_sel  = m1_sel_i;
                g_addr = m1_addr_i;
                g_data = m1_data_i;
            end
            default: begin
            end
        endcase
    end

    // Strobe is withheld in the expiry cycle so the slave sees a clean abort
    assign s_cyc_o  = g_cyc;
    assign s_stb_o  = g_stb & ~expire;
    assign s_we_o   = g_we;
    assign s_sel_o  = g_sel;
    assign s_addr_o = g_addr;
    assign s_data_o = g_data;

    assign wd_clr = (gnt_d != gnt_q) | s_ack_i | ~s_stb_o;
    assign wd_run = s_stb_o & ~s_ack_i;

    wb_ram_arb_wdog u_wdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (wd_clr),
        .run     (wd_run),
        .limit   (LIMIT),
        .expire  (expire)
    );

    // An ack arriving after the master dropped cyc is discarded
    assign ack_hit = s_ack_i & g_cyc;
    assign err_hit = expire & g_cyc & g_stb & ~s_ack_i;

    assign m0_ack_o = ack_hit & gnt_q[0];
    assign m1_ack_o = ack_hit & gnt_q[1];
    assign m0_err_o = err_hit & gnt_q[0];
    assign m1_err_o = err_hit & gnt_q[1];

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter with a behavioural 32x512 RAM.
// Table-driven transfers plus directed multi-cycle corner sequences.
module tb_wb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [10:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [10:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [10:0] s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic        s_ack;
    logic [1:0]  gnt;

    wb_ram_arbiter #(.AW(11), .DW(32), .TMO(15)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_sel_i  (m0_sel),
        .m0_addr_i (m0_addr),
        .m0_data_i (m0_wdata),
        .m0_data_o (m0_rdata),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_sel_i  (m1_sel),
        .m1_addr_i (m1_addr),
        .m1_data_i (m1_wdata),
        .m1_data_o (m1_rdata),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_ack_i   (s_ack),
        .s_data_i  (s_rdata),
        .gnt_o     (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered ack and read data, byte-lane writes
    logic [31:0] mem [0:511];
    logic        ram_ack_q, ram_en, force_ack;
    logic [31:0] ram_rd_q;

    assign s_ack   = ram_ack_q | force_ack;
    assign s_rdata = ram_rd_q;

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ack_q <= 1'b0;
            ram_rd_q  <= 32'hC0FFEE00;
        end else begin
            ram_ack_q <= 1'b0;
            if (ram_en && s_cyc && s_stb && !ram_ack_q) begin
                ram_ack_q <= 1'b1;
                ram_rd_q  <= mem[s_addr[10:2]];
                if (s_we)
                    mem[s_addr[10:2]] <= (mem[s_addr[10:2]] & ~bmask(s_sel))
                                       | (s_wdata & bmask(s_sel));
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Event monitor, sampled at negedge+1 before any stimulus change
    int ack0_n = 0, ack1_n = 0, err0_n = 0, err1_n = 0;
    int both_n = 0, gskip_n = 0;
    logic [1:0] gnt_prev = 2'b00;

    always begin
        @(negedge clk);
        #1;
        if (m0_ack) ack0_n++;
        if (m1_ack) ack1_n++;
        if (m0_err) err0_n++;
        if (m1_err) err1_n++;
        if ((m0_ack && m0_err) || (m1_ack && m1_err)) both_n++;
        if (gnt_prev != 2'b00 && gnt != 2'b00 && gnt != gnt_prev) gskip_n++;
        gnt_prev = gnt;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb,
                         input logic we, input logic [10:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we;
            m0_addr = a; m0_sel = s; m0_wdata = d;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we;
            m1_addr = a; m1_sel = s; m1_wdata = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
        force_ack = 1'b0;
        ram_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic xfer(input int m, input logic we, input logic [10:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic got, output logic [31:0] rd);
        got = 1'b0;
        rd = '0;
        @(negedge clk);
        #2;
        drive(m, 1, 1, we, a, s, d);
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                rd = (m == 0) ? m0_rdata : m1_rdata;
            end
        end
        #1;
        drive(m, 0, 0, 0, '0, '0, '0);
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [10:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic        got;
        logic [31:0] rd;
        int a0, a1, e0, e1, st, ea;
        logic [1:0] exp_g;

        tbl[0] = '{0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1, 1'b0, 11'h010, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{0, 1'b1, 11'h020, 4'hF, 32'h11223344, 32'h0};
        tbl[3] = '{1, 1'b1, 11'h020, 4'h2, 32'h0000AB00, 32'h0};
        tbl[4] = '{0, 1'b0, 11'h020, 4'hF, 32'h0,        32'h1122AB44};
        tbl[5] = '{1, 1'b1, 11'h7FC, 4'hF, 32'hA5A55A5A, 32'h0};
        tbl[6] = '{0, 1'b0, 11'h7FC, 4'hF, 32'h0,        32'hA5A55A5A};

        // Reset state with both masters actively requesting
        rst_n = 1'b0;
        force_ack = 1'b0;
        ram_en = 1'b1;
        drive(0, 1, 1, 1, 11'h7FC, 4'hF, 32'h12345678);
        drive(1, 1, 1, 1, 11'h7FC, 4'hF, 32'h12345678);
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc_stb", 32'({s_cyc, s_stb, s_we}), 32'h0);
        chk("rst_s_sel_addr", 32'({s_sel, s_addr}), 32'h0);
        chk("rst_s_data", s_wdata, 32'h0);
        chk("rst_ack_err", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
        chk("rst_m1_data_follow", m1_rdata, 32'hC0FFEE00);
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            a0 = ack0_n; a1 = ack1_n; e0 = err0_n; e1 = err1_n;
            xfer(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wd,
                 got, rd);
            chk($sformatf("v%0d_ack", i), 32'(got), 32'h1);
            if (!tbl[i].we)
                chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp);
            chk($sformatf("v%0d_own_acks", i),
                32'((tbl[i].m == 0) ? ack0_n - a0 : ack1_n - a1), 32'h1);
            chk($sformatf("v%0d_other_acks", i),
                32'((tbl[i].m == 0) ? ack1_n - a1 : ack0_n - a0), 32'h0);
            chk($sformatf("v%0d_errs", i),
                32'(err0_n - e0 + err1_n - e1), 32'h0);
        end

        // Late ack after m1 drops cyc must not reach m1
        ram_en = 1'b0;
        a1 = ack1_n;
        @(negedge clk);
        #2;
        drive(1, 1, 1, 0, 11'h010, 4'hF, 32'h0);
        tick();
        chk("drop_granted", 32'(gnt), 32'h2);
        #1;
        drive(1, 0, 0, 0, '0, '0, '0);
        force_ack = 1'b1;
        #1;
        chk("late_ack_same_cycle", 32'(m1_ack), 32'h0);
        tick();
        chk("drop_release", 32'(gnt), 32'h0);
        chk("late_ack_next_cycle", 32'(m1_ack), 32'h0);
        #1;
        force_ack = 1'b0;
        chk("late_ack_count", 32'(ack1_n - a1), 32'h0);

        // Ack never arrives: err on the 16th strobe cycle
        a0 = ack0_n; e0 = err0_n;
        @(negedge clk);
        #2;
        drive(0, 1, 1, 0, 11'h040, 4'hF, 32'h0);
        st = -1;
        ea = -1;
        for (int i = 1; i <= 40 && ea < 0; i++) begin
            tick();
            if (st < 0 && s_stb) st = i;
            if (m0_err) begin
                ea = i;
                chk("tmo_stb_forced_low", 32'(s_stb), 32'h0);
                chk("tmo_gnt_kept", 32'(gnt), 32'h1);
            end
        end
        chk("tmo_cycle", 32'(ea - st + 1), 32'd16);
        tick();
        chk("tmo_err_one_cycle", 32'(m0_err), 32'h0);
        chk("tmo_stb_resumes", 32'(s_stb), 32'h1);
        #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        chk("tmo_no_ack", 32'(ack0_n - a0), 32'h0);
        chk("tmo_err_once", 32'(err0_n - e0), 32'h1);

        // Ack lands in the expiry cycle: ack wins
        a0 = ack0_n; e0 = err0_n;
        @(negedge clk);
        #2;
        drive(0, 1, 1, 0, 11'h040, 4'hF, 32'h0);
        repeat (15) tick();
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        tick();
        chk("coin_ack", 32'(m0_ack), 32'h1);
        chk("coin_err", 32'(m0_err), 32'h0);
        #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        force_ack = 1'b0;
        chk("coin_ack_count", 32'(ack0_n - a0), 32'h1);
        chk("coin_err_count", 32'(err0_n - e0), 32'h0);

        // Round robin from reset: ties go 0, 1, 0
        do_reset();
        for (int r = 0; r < 3; r++) begin
            exp_g = (r == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            #2;
            drive(0, 1, 1, 0, 11'h010, 4'hF, 32'h0);
            drive(1, 1, 1, 0, 11'h010, 4'hF, 32'h0);
            tick();
            chk($sformatf("rr%0d_gnt", r), 32'(gnt), 32'(exp_g));
            #1;
            drive(exp_g[0] ? 1 : 0, 0, 0, 0, '0, '0, '0);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                got = exp_g[0] ? m0_ack : m1_ack;
            end
            chk($sformatf("rr%0d_ack", r), 32'(got), 32'h1);
            #1;
            drive(exp_g[0] ? 0 : 1, 0, 0, 0, '0, '0, '0);
            tick();
            chk($sformatf("rr%0d_idle", r), 32'(gnt), 32'h0);
        end

        // Reset in the middle of a granted m0 read
        do_reset();
        a0 = ack0_n; e0 = err0_n; e1 = err1_n;
        @(negedge clk);
        #2;
        drive(0, 1, 1, 0, 11'h010, 4'hF, 32'h0);
        tick();
        chk("mid_rst_granted", 32'(gnt), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_s_ctl", 32'({s_cyc, s_stb, s_we, s_sel}), 32'h0);
        chk("mid_rst_s_addr", 32'(s_addr), 32'h0);
        chk("mid_rst_ack_err", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
        chk("mid_rst_data_follow", m0_rdata, 32'hC0FFEE00);
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 1, 1, 0, 11'h010, 4'hF, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_m1_gnt", 32'(gnt), 32'h2);
        chk("post_rst_s_cyc", 32'(s_cyc), 32'h1);
        #1;
        drive(1, 0, 0, 0, '0, '0, '0);
        tick();
        chk("mid_rst_no_m0_ack", 32'(ack0_n - a0), 32'h0);
        chk("mid_rst_no_err", 32'(err0_n - e0 + err1_n - e1), 32'h0);

        chk("ack_err_overlap", 32'(both_n), 32'h0);
        chk("gnt_direct_switch", 32'(gskip_n), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
